// File: rtl/uart_word_sender_if.sv
// Write-side handshake into uart_word_sender: one 32-bit word or one byte per accepted request.
interface uart_word_sender_if;
   logic [31:0] wdata;
   logic        wsize;
   logic        wvalid;
   logic        wready;

   modport master (output wdata, output wsize, output wvalid, input wready);
   modport slave  (input wdata, input wsize, input wvalid, output wready);
endinterface

// File: rtl/uart_word_sender.sv
// Queues 32-bit words or single bytes from the core and sends them as 8N1 UART frames,
// words MSB byte first, through a 16-entry FIFO and a built-in bit serializer.
module uart_word_sender #(
   parameter int CLK_PER_HALF_BIT = 434,
   parameter int FIFO_SIZE        = 4
) (
   input  logic              clk,
   input  logic              rst,
   uart_word_sender_if.slave wr,
   output logic              txd,
   output logic              busy
);

   localparam int DEPTH    = 1 << FIFO_SIZE;
   localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
   localparam int TW       = $clog2(BIT_CLKS);

   localparam logic [TW-1:0]      BIT_LAST   = TW'(BIT_CLKS - 1);
   localparam logic [FIFO_SIZE:0] FULL_COUNT = (FIFO_SIZE + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND
   } seq_state_t;

   // FIFO storage and bookkeeping
   logic [32:0]          mem [DEPTH];
   logic [FIFO_SIZE-1:0] wr_ptr_reg;
   logic [FIFO_SIZE-1:0] rd_ptr_reg;
   logic [FIFO_SIZE:0]   count_reg;
   logic [FIFO_SIZE:0]   count_next;
   logic                 wready_reg;
   logic                 busy_reg;
   logic [32:0]          head;

   // byte sequencer
   seq_state_t           state_reg;
   logic [31:0]          hold_reg;
   logic [2:0]           bytes_left_reg;
   logic [7:0]           lane [4];
   logic [7:0]           cur_byte;

   // bit serializer
   logic [7:0]           ser_buf_reg;
   logic                 ser_pending_reg;
   logic                 ser_active_reg;
   logic [8:0]           shift_reg;
   logic [3:0]           bit_idx_reg;
   logic [TW-1:0]        timer_reg;
   logic                 txd_reg;

   logic                 push;
   logic                 pop;
   logic                 fifo_empty;
   logic                 bit_end;
   logic                 frame_last;
   logic                 ser_take;
   logic                 frame_end;
   logic                 last_done;
   logic                 go_idle;

   assign push       = wr.wvalid & wready_reg;
   assign fifo_empty = (count_reg == '0);
   assign head       = mem[rd_ptr_reg];

   assign bit_end    = ser_active_reg && (timer_reg == BIT_LAST);
   assign frame_last = bit_end && (bit_idx_reg == 4'd9);
   // A queued byte starts either from idle or exactly as the previous stop bit ends.
   assign ser_take   = ser_pending_reg && (!ser_active_reg || frame_last);
   assign frame_end  = frame_last && !ser_pending_reg;

   assign last_done  = (state_reg == S_SEND) && (bytes_left_reg == 3'd1) && frame_end;
   assign pop        = !fifo_empty && ((state_reg == S_IDLE) || last_done);
   assign go_idle    = fifo_empty && ((state_reg == S_IDLE) || last_done);

   assign count_next = count_reg + {{FIFO_SIZE{1'b0}}, push} - {{FIFO_SIZE{1'b0}}, pop};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = hold_reg[8*gi +: 8];
      end
   endgenerate

   // bytes_left doubles as the lane index: 4 -> bits 31:24 ... 1 -> bits 7:0
   assign cur_byte = lane[2'(bytes_left_reg - 3'd1)];

   assign wr.wready = wready_reg;
   assign txd       = txd_reg;
   assign busy      = busy_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {wr.wsize, wr.wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         wready_reg <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg  <= count_next;
         // A pop this cycle cannot make room for a push until the next cycle.
         wready_reg <= (count_next != FULL_COUNT);
         busy_reg   <= !go_idle || (count_next != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_IDLE;
         hold_reg        <= '0;
         bytes_left_reg  <= '0;
         ser_buf_reg     <= '0;
         ser_pending_reg <= 1'b0;
         ser_active_reg  <= 1'b0;
         shift_reg       <= '1;
         bit_idx_reg     <= '0;
         timer_reg       <= '0;
         txd_reg         <= 1'b1;
      end else begin
         if (ser_take) begin
            shift_reg       <= {1'b1, ser_buf_reg};
            txd_reg         <= 1'b0;
            bit_idx_reg     <= '0;
            timer_reg       <= '0;
            ser_active_reg  <= 1'b1;
            ser_pending_reg <= 1'b0;
         end else if (ser_active_reg) begin
            if (bit_end) begin
               timer_reg <= '0;
               if (bit_idx_reg == 4'd9) begin
                  ser_active_reg <= 1'b0;
               end else begin
                  txd_reg     <= shift_reg[0];
                  shift_reg   <= {1'b1, shift_reg[8:1]};
                  bit_idx_reg <= bit_idx_reg + 4'd1;
               end
            end else begin
               timer_reg <= timer_reg + 1'b1;
            end
         end

         case (state_reg)
            S_IDLE: begin
               if (pop) begin
                  state_reg <= S_LOAD;
               end
            end
            S_LOAD: begin
               ser_buf_reg     <= cur_byte;
               ser_pending_reg <= 1'b1;
               state_reg       <= S_SEND;
            end
            S_SEND: begin
               // Inner bytes are prefetched as soon as the serializer takes the
               // current one, so frames of a word follow with no idle gap.
               if (bytes_left_reg != 3'd1) begin
                  if (ser_take) begin
                     bytes_left_reg <= bytes_left_reg - 3'd1;
                     state_reg      <= S_LOAD;
                  end
               end else if (frame_end) begin
                  state_reg <= pop ? S_LOAD : S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase

         if (pop) begin
            hold_reg       <= head[31:0];
            bytes_left_reg <= head[32] ? 3'd4 : 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed bench for uart_word_sender: stimulus pushes expected bytes into a scoreboard,
// a UART receiver process decodes txd and checks each frame against it.
module tb_uart_word_sender;
   localparam int HALF = 4;
   localparam int BIT  = 2 * HALF;

   logic clk = 1'b0;
   logic rst;
   logic txd;
   logic busy;

   uart_word_sender_if wr_if ();

   uart_word_sender #(
      .CLK_PER_HALF_BIT(HALF),
      .FIFO_SIZE       (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wr  (wr_if),
      .txd (txd),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   int         rx_count = 0;
   bit         rx_active = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_shift = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   // UART receiver: samples mid-bit on the falling clock edge, abandons a frame on reset.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            rx_active = 1'b0;
         end else if (!rx_active) begin
            if (txd === 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt == BIT/2) begin
               check("rx_start_bit", {31'd0, txd}, 32'd0);
            end else if (rx_cnt > BIT/2 && rx_cnt < BIT/2 + 9*BIT && ((rx_cnt - BIT/2) % BIT) == 0) begin
               rx_shift = {txd, rx_shift[7:1]};
            end else if (rx_cnt == BIT/2 + 9*BIT) begin
               rx_active = 1'b0;
               rx_count++;
               check("rx_stop_bit", {31'd0, txd}, 32'd1);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL rx_unexpected: got byte 0x%02h, expected no byte", rx_shift);
               end else begin
                  e = exp_q.pop_front();
                  $display("rx byte 0x%02h (expected 0x%02h) at cycle %0d", rx_shift, e, cyc);
                  check("rx_byte", {24'd0, rx_shift}, {24'd0, e});
               end
            end
         end
      end
   end

   // Called just after a falling edge; returns the index of the accepting clock edge.
   task automatic push_entry(input logic sz, input logic [31:0] d, input bit keep_valid,
                             output int edge_cyc, output int stalls);
      int g;
      g = 0;
      wr_if.wdata  = d;
      wr_if.wsize  = sz;
      wr_if.wvalid = 1'b1;
      while (wr_if.wready !== 1'b1 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      stalls = g;
      if (g >= 2000) begin
         bound_fail("push_accept");
         wr_if.wvalid = 1'b0;
         edge_cyc = cyc;
      end else begin
         @(posedge clk);
         @(negedge clk);
         edge_cyc = cyc;
         if (!keep_valid) wr_if.wvalid = 1'b0;
         if (sz) begin
            exp_q.push_back(d[31:24]);
            exp_q.push_back(d[23:16]);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
         end else begin
            exp_q.push_back(d[7:0]);
         end
         $display("push size=%0d data=0x%08h at edge %0d", sz, d, edge_cyc);
      end
   endtask

   task automatic wait_fall(output int f);
      int g;
      g = 0;
      while (txd !== 1'b0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) bound_fail("txd_fall");
      f = cyc;
   endtask

   task automatic wait_busy_low(output int c);
      int g;
      g = 0;
      while (busy !== 1'b0 && g < 10000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 10000) bound_fail("busy_fall");
      c = cyc;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((busy !== 1'b0 || rx_active) && g < 10000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 10000) bound_fail("drain");
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #700000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, f, c, st, tot_st, t0, g, lows, rx_before;
      logic [9:0] pat;
      rst          = 1'b1;
      wr_if.wvalid = 1'b0;
      wr_if.wsize  = 1'b0;
      wr_if.wdata  = '0;

      repeat (3) @(negedge clk);
      check("reset_wready", {31'd0, wr_if.wready}, 32'd0);
      check("reset_busy",   {31'd0, busy}, 32'd0);
      check("reset_txd",    {31'd0, txd}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("wready_after_reset", {31'd0, wr_if.wready}, 32'd1);

      // single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
      pat = 10'b11_0100_1010;
      push_entry(1'b0, 32'h0000_00A5, 1'b0, t, st);
      wait_fall(f);
      check("byte_latency", f - t, 32'd3);
      g = 0;
      c = -1;
      for (int k = 0; k < 10 * BIT; k++) begin
         if (txd !== pat[k / BIT]) g++;
         if (c < 0 && busy === 1'b0) c = cyc;
         @(negedge clk);
      end
      check("byte_bit_pattern_errors", g, 32'd0);
      if (c < 0) wait_busy_low(c);
      check("byte_busy_fall", c - f, 32'd80);
      wait_idle();

      // word order and gapless framing
      push_entry(1'b1, 32'h1234_5678, 1'b0, t, st);
      wait_fall(f);
      check("word_latency", f - t, 32'd3);
      wait_busy_low(c);
      check("word_duration", c - f, 32'd320);
      wait_idle();

      // back-pressure: 17 words with wvalid held high
      tot_st = 0;
      t0 = 0;
      for (int i = 0; i < 17; i++) begin
         push_entry(1'b1, {8'(8'h10 + i), 8'(8'h30 + i), 8'(8'h50 + i), 8'(8'h70 + i)}, 1'b1, t, st);
         if (i == 0) t0 = t;
         tot_st += st;
      end
      wr_if.wvalid = 1'b0;
      check("bp_stalls_first_17", tot_st, 32'd0);
      check("bp_wready_full", {31'd0, wr_if.wready}, 32'd0);
      g = 0;
      while (wr_if.wready !== 1'b1 && g < 1000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 1000) bound_fail("bp_wready_rise");
      else check("bp_wready_rise_edge", cyc - t0, 32'd323);
      wait_idle();

      // mixed sizes
      push_entry(1'b0, 32'h0000_000A, 1'b0, t, st);
      push_entry(1'b1, 32'hDEAD_BEEF, 1'b0, t, st);
      push_entry(1'b0, 32'h0000_00FF, 1'b0, t, st);
      wait_idle();

      // reset during data bit 3 of the second byte of a word, three entries queued
      push_entry(1'b1, 32'hCAFE_F00D, 1'b0, t0, st);
      push_entry(1'b0, 32'h0000_0011, 1'b0, t, st);
      push_entry(1'b0, 32'h0000_0022, 1'b0, t, st);
      push_entry(1'b0, 32'h0000_0033, 1'b0, t, st);
      while (cyc < t0 + 83 + 34) @(negedge clk);
      check("mid_frame_txd_before_reset", {31'd0, txd}, {31'd0, 1'b0 ^ 1'b1 ^ 1'b1 ^ 1'b1});
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete();
      check("rst_edge_txd",    {31'd0, txd}, 32'd1);
      check("rst_edge_busy",   {31'd0, busy}, 32'd0);
      check("rst_edge_wready", {31'd0, wr_if.wready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_wready", {31'd0, wr_if.wready}, 32'd1);
      check("post_rst_busy",   {31'd0, busy}, 32'd0);
      rx_before = rx_count;
      lows = 0;
      for (int k = 0; k < 200; k++) begin
         if (txd !== 1'b1) lows++;
         @(negedge clk);
      end
      check("post_rst_txd_low_samples", lows, 32'd0);
      check("post_rst_frames", rx_count - rx_before, 32'd0);

      // pointer wrap: 40 bytes in bursts of 10
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 10; j++) begin
            push_entry(1'b0, 32'(b * 10 + j), 1'b0, t, st);
         end
         wait_idle();
      end

      check("scoreboard_left", exp_q.size(), 32'd0);
      check("rx_total_frames", rx_count, 32'd120);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
